// File: rtl/shadow_dump_pkg.sv
// Shared types for the shadow dump receiver.
// Holds the receive FSM state encoding and the trailer word layout.
package shadow_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DUMP,
    PAD,
    TRAIL
  } state_t;

  // The trailer word is {overflow, saturated bit count}, so the count field
  // is one bit narrower than the word.
  function automatic int unsigned trl_cnt_w(input int unsigned word_w);
    return word_w - 1;
  endfunction

endpackage

// File: rtl/shadow_dump_rx_if.sv
// Word-level valid/ready port between the dump receiver and the debug host.
// word_last marks the trailer word of a dump.
interface shadow_dump_rx_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] word_out;
  logic              word_vld;
  logic              word_rdy;
  logic              word_last;

  modport master (output word_out, output word_vld, output word_last, input word_rdy);
  modport slave  (input word_out, input word_vld, input word_last, output word_rdy);
endinterface

// File: rtl/shadow_rx_fifo.sv
// Synchronous FIFO buffering received words (data plus last flag).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module shadow_rx_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/shadow_dump_rx.sv
// Receiving end of a shadow_capture dump chain: deserialises the 1-bit stream
// into words, appends a trailer and hands them to the host through a FIFO.
module shadow_dump_rx
  import shadow_dump_pkg::*;
#(
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             sh_clk,
  input  logic             sh_rst,
  input  logic             start,
  output logic             dump_en,
  input  logic             ch_in,
  input  logic             ch_in_vld,
  input  logic             ch_in_done,
  shadow_dump_rx_if.master host,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic             overflow,
  output logic             err_proto
);
  localparam int unsigned       PART_W      = $clog2(WORD_W);
  localparam int unsigned       TRL_CNT_W   = trl_cnt_w(WORD_W);
  localparam logic [CNT_W-1:0]  TRL_CNT_MAX = CNT_W'((1 << TRL_CNT_W) - 1);
  localparam logic [PART_W-1:0] PART_LAST   = PART_W'(WORD_W - 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [PART_W-1:0]   part_q, part_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic                fifo_push;
  logic [WORD_W:0]     fifo_din;
  logic [WORD_W:0]     fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                can_push;
  logic                accept_start;
  logic [TRL_CNT_W-1:0] trl_cnt;

  assign pop          = host.word_vld && host.word_rdy;
  assign can_push     = !fifo_full || pop;
  assign accept_start = start && !busy;
  assign trl_cnt      = (cnt_q > TRL_CNT_MAX) ? '1 : cnt_q[TRL_CNT_W-1:0];

  shadow_rx_fifo #(
    .WIDTH (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sh_clk),
    .rst     (sh_rst),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge sh_clk) begin
    if (sh_rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept_start) state_d = DUMP;
      DUMP:    if (ch_in_done) state_d = PAD;
      PAD:     if (part_q == '0 || can_push) state_d = TRAIL;
      TRAIL:   if (can_push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and infers a latch.
  always_comb begin
    sh_d      = sh_q;
    part_d    = part_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    fifo_push = 1'b0;
    fifo_din  = '0;
    unique case (state_q)
      IDLE: begin
        if (accept_start) begin
          sh_d   = '0;
          part_d = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          err_d  = 1'b0;
        end
      end
      DUMP: begin
        if (ch_in_vld) begin
          sh_d[part_q] = ch_in;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (part_q == PART_LAST) begin
            // The stream cannot stall, so a full FIFO loses this word.
            fifo_push = can_push;
            fifo_din  = {1'b0, sh_d};
            ovf_d     = ovf_q || !can_push;
            sh_d      = '0;
            part_d    = '0;
          end else begin
            part_d = part_q + PART_W'(1);
          end
        end
      end
      PAD: begin
        if (part_q != '0 && can_push) begin
          fifo_push = 1'b1;
          fifo_din  = {1'b0, sh_q};
          sh_d      = '0;
          part_d    = '0;
        end
      end
      TRAIL: begin
        fifo_push = can_push;
        fifo_din  = {1'b1, ovf_q, trl_cnt};
      end
      default: ;
    endcase
    // Stray stream activity outside DUMP is flagged even in a start cycle.
    if (state_q != DUMP && (ch_in_vld || ch_in_done)) err_d = 1'b1;
  end

  always_comb begin
    dump_en   = (state_q == DUMP);
    busy      = (state_q != IDLE) || !fifo_empty;
    bit_count = cnt_q;
    overflow  = ovf_q;
    err_proto = err_q;
  end

  // Gate the unreset storage so the word port reads zero while empty.
  assign host.word_vld  = !fifo_empty;
  assign host.word_out  = fifo_empty ? '0 : fifo_dout[WORD_W-1:0];
  assign host.word_last = !fifo_empty && fifo_dout[WORD_W];

endmodule

// File: tb/tb_shadow_dump_rx.sv
// Self-checking bench for shadow_dump_rx with WORD_W=8, FIFO_DEPTH=4.
// Table of whole dumps plus hand sequences for protocol errors and reset.
module tb_shadow_dump_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dump_en;
  logic        ch_in = 1'b0;
  logic        ch_in_vld = 1'b0;
  logic        ch_in_done = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] bit_count;
  logic        busy;
  logic        overflow;
  logic        err_proto;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0] got [$];

  shadow_dump_rx_if #(.WORD_W(8)) host_if ();
  assign host_if.word_rdy = rdy;

  shadow_dump_rx #(
    .WORD_W     (8),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .sh_clk     (clk),
    .sh_rst     (rst),
    .start      (start),
    .dump_en    (dump_en),
    .ch_in      (ch_in),
    .ch_in_vld  (ch_in_vld),
    .ch_in_done (ch_in_done),
    .host       (host_if),
    .bit_count  (bit_count),
    .busy       (busy),
    .overflow   (overflow),
    .err_proto  (err_proto)
  );

  always #5 clk = ~clk;

  // Record every word the host accepts; inputs settle 1 time unit after posedge.
  always @(negedge clk) begin
    if (host_if.word_vld && host_if.word_rdy)
      got.push_back({host_if.word_last, host_if.word_out});
  end

  typedef struct {
    int          nbits;
    logic [63:0] bits;
    logic        done_on_last;
    logic        rdy;
    int          n_exp;
    logic [47:0] exp_w;
    logic        exp_ovf;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic done);
    ch_in      = b;
    ch_in_vld  = 1'b1;
    ch_in_done = done;
    step();
    ch_in_vld  = 1'b0;
    ch_in_done = 1'b0;
  endtask

  task automatic send_done();
    ch_in_done = 1'b1;
    step();
    ch_in_done = 1'b0;
  endtask

  // Wait (bounded) for the receiver to drain, then compare the accepted words.
  task automatic expect_words(input string tag, input int n, input logic [47:0] w);
    int          cyc = 0;
    logic [8:0]  exp;
    logic [8:0]  act;
    while (busy && cyc < 200) begin
      step();
      cyc++;
    end
    check($sformatf("%s drained", tag), 32'(busy), 32'(0));
    check($sformatf("%s word count", tag), 32'(got.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      exp = {k == n - 1, w[k*8 +: 8]};
      act = (k < got.size()) ? got[k] : 9'h1FF;
      check($sformatf("%s word %0d {last,data}", tag, k), 32'(act), 32'(exp));
    end
  endtask

  initial begin
    vec_t v;

    vecs[0] = '{nbits: 16, bits: 64'h3CA5, done_on_last: 1'b0, rdy: 1'b1,
                n_exp: 3, exp_w: 48'h10_3C_A5, exp_ovf: 1'b0, exp_cnt: 16};
    vecs[1] = '{nbits: 12, bits: 64'hAFF, done_on_last: 1'b0, rdy: 1'b1,
                n_exp: 3, exp_w: 48'h0C_0A_FF, exp_ovf: 1'b0, exp_cnt: 12};
    vecs[2] = '{nbits: 48, bits: 64'h0605_0403_0201, done_on_last: 1'b0, rdy: 1'b0,
                n_exp: 5, exp_w: 48'hB0_04_03_02_01, exp_ovf: 1'b1, exp_cnt: 48};
    vecs[3] = '{nbits: 8, bits: 64'h5A, done_on_last: 1'b1, rdy: 1'b1,
                n_exp: 2, exp_w: 48'h08_5A, exp_ovf: 1'b0, exp_cnt: 8};
    vecs[4] = '{nbits: 3, bits: 64'h5, done_on_last: 1'b1, rdy: 1'b1,
                n_exp: 2, exp_w: 48'h03_05, exp_ovf: 1'b0, exp_cnt: 3};

    // Reset state
    step();
    step();
    rst = 1'b0;
    step();
    check("reset dump_en",   32'(dump_en),           32'(0));
    check("reset word_vld",  32'(host_if.word_vld),  32'(0));
    check("reset word_out",  32'(host_if.word_out),  32'(0));
    check("reset word_last", 32'(host_if.word_last), 32'(0));
    check("reset busy",      32'(busy),              32'(0));
    check("reset bit_count", 32'(bit_count),         32'(0));
    check("reset overflow",  32'(overflow),          32'(0));
    check("reset err_proto", 32'(err_proto),         32'(0));

    // Stray vld in IDLE sets err_proto until the next accepted start
    rdy = 1'b1;
    send_bit(1'b1, 1'b0);
    check("err set by idle vld", 32'(err_proto), 32'(1));
    step();
    check("err sticky", 32'(err_proto), 32'(1));
    pulse_start();
    check("err cleared by start", 32'(err_proto), 32'(0));
    check("dump_en after start",  32'(dump_en),   32'(1));

    // start during DUMP is ignored: count keeps running
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    pulse_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("mid-dump start bit_count", 32'(bit_count), 32'(5));
    check("mid-dump start dump_en",   32'(dump_en),   32'(1));
    check("err clear in dump",        32'(err_proto), 32'(0));
    send_done();
    check("dump_en off after done", 32'(dump_en), 32'(0));
    got.delete();
    expect_words("ignored start", 2, 48'h05_0B);

    // sh_rst mid-dump flushes buffered and partial data
    rdy = 1'b0;
    pulse_start();
    for (int i = 0; i < 13; i++) send_bit(1'b1, 1'b0);
    check("pre-reset word_vld", 32'(host_if.word_vld), 32'(1));
    rst = 1'b1;
    step();
    check("mid reset dump_en",   32'(dump_en),          32'(0));
    check("mid reset word_vld",  32'(host_if.word_vld), 32'(0));
    check("mid reset busy",      32'(busy),             32'(0));
    check("mid reset bit_count", 32'(bit_count),        32'(0));
    rst = 1'b0;
    got.delete();

    // Table of complete dumps; the first one also proves restart after reset
    for (int t = 0; t < 5; t++) begin
      v = vecs[t];
      got.delete();
      rdy = v.rdy;
      pulse_start();
      check($sformatf("v%0d dump_en on", t), 32'(dump_en), 32'(1));
      for (int i = 0; i < v.nbits; i++) begin
        send_bit(v.bits[i], v.done_on_last && (i == v.nbits - 1));
        if (i == 7) begin
          check($sformatf("v%0d first word vld", t), 32'(host_if.word_vld), 32'(1));
          check($sformatf("v%0d first word", t), 32'(host_if.word_out), 32'(v.exp_w[7:0]));
        end
      end
      if (!v.done_on_last) send_done();
      check($sformatf("v%0d dump_en off", t), 32'(dump_en), 32'(0));
      if (!v.rdy) begin
        step();
        step();
        check($sformatf("v%0d held word", t), 32'(host_if.word_out), 32'(v.exp_w[7:0]));
        check($sformatf("v%0d still busy", t), 32'(busy), 32'(1));
        rdy = 1'b1;
      end
      expect_words($sformatf("v%0d", t), v.n_exp, v.exp_w);
      check($sformatf("v%0d bit_count", t), 32'(bit_count), 32'(v.exp_cnt));
      check($sformatf("v%0d overflow", t),  32'(overflow),  32'(v.exp_ovf));
      check($sformatf("v%0d err_proto", t), 32'(err_proto), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
